instr_mem_fetch: RTL and testbench
==================================

Name: instr_mem_fetch

Overview:
Parametrised, synchronous instruction memory with a valid/ready fetch interface. It replaces the fixed 32-byte, reset-preloaded instruction store. The core's fetch stage issues byte PCs and receives 32-bit instructions one cycle later. A loader port programs the array word by word. After reset, an init sequencer fills the whole array with NOPs before any fetch is accepted.

Parameters:
DEPTH, 64, number of 32-bit instruction words; power of two, minimum 4.
NOP_WORD, 32'h0000_0013, fill value after reset and the instruction returned on a fault (addi x0,x0,0).
AW, $clog2(DEPTH), localparam, word-index width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
init_done  out  1  high once the NOP fill is complete.
load_en  in  1  write one word to the array this cycle.
load_addr  in  AW  word index to write.
load_data  in  32  instruction word, little-endian byte order as fetched.
fetch_req_valid  in  1  fetch request present.
fetch_req_ready  out  1  block can accept a request.
fetch_pc  in  32  byte address of the instruction.
fetch_rsp_valid  out  1  response register holds a result.
fetch_rsp_ready  in  1  consumer takes the response.
fetch_instr  out  32  fetched instruction.
fetch_fault  out  1  misaligned or out-of-range PC.

Behaviour:
- Reset is synchronous, active-high, with one clock:
  - outputs go to init_done=0, fetch_req_ready=0, fetch_rsp_valid=0, fetch_instr=NOP_WORD, fetch_fault=0;
  - the fill counter clears to 0 and the FSM enters INIT.
- FSM INIT:
  - each cycle writes NOP_WORD to mem[cnt] and increments cnt;
  - when cnt==DEPTH-1 is written, the next state is RUN and init_done=1 from the following cycle;
  - INIT lasts exactly DEPTH cycles;
  - load_en and fetch_req_valid are ignored; fetch_req_ready=0.
- FSM RUN is held until reset.
  - fetch_req_ready = !fetch_rsp_valid || fetch_rsp_ready, i.e. a 1-entry output register with full throughput.
- Handshake: a request is accepted when fetch_req_valid && fetch_req_ready.
  - Latency is 1 cycle: on the next edge fetch_rsp_valid=1 and fetch_instr/fetch_fault are updated.
  - If the response is consumed and no new request is accepted, fetch_rsp_valid clears.
  - While fetch_rsp_valid && !fetch_rsp_ready, the fetch_instr/fetch_fault values are held stable.
  - Back-to-back accepted fetches produce one response per cycle.
- Addressing: the word index is fetch_pc[AW+1:2].
  - fault = (fetch_pc[1:0]!=0) || (fetch_pc[31:AW+2]!=0).
  - On a fault: fetch_instr=NOP_WORD and fetch_fault=1; the array is not read.
- Load (RUN only): mem[load_addr] <= load_data at the edge.
- Load and fetch of the same word in the same cycle: the fetch returns the OLD contents (read-before-write).
- Reset mid-operation: any pending response is dropped (fetch_rsp_valid=0) and a full INIT restarts; previously loaded contents are overwritten with NOPs.
- The array is inferable as a single-port-write / single-port-read synchronous RAM. There is no combinational path from the fetch_* inputs to fetch_instr.

Optional Feature:
IMEM_BYTE_LOAD_EN
- Defined:
  - adds input port load_be [3:0];
  - a load writes only the bytes whose enable bit is set; byte i = load_data[8i+7:8i];
  - a load with load_be=0 is a no-op.
- Undefined: the port is absent and every load writes all 4 bytes.
- The INIT fill always writes full words in both builds.

Decomposition:
- Shared package imem_pkg holds:
  - NOP_WORD;
  - the FSM state typedef (IMEM_INIT, IMEM_RUN);
  - the fault-reason constant;
  - the instruction width constant (32).
- One sub-module, imem_ram: parametrised DEPTH x 32 synchronous RAM with 1-cycle read, optional byte enables and read-before-write. The top module holds the FSM, fill counter, fault logic and output register.

Test Plan:
- Reset, then hold fetch_req_valid=1 with DEPTH=64 -> init_done rises on cycle 65 after reset deassert; fetch_req_ready=0 until then; first response = 32'h00000013, fault=0.
- Load words 0..7 with 32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33, ..., then fetch PCs 0,4,...,28 back-to-back with rsp_ready=1 -> 8 consecutive responses in order, one per cycle, values match.
- Fetch PC 0x4 with rsp_ready=0 for 3 cycles -> rsp_valid stays 1, instr stays 32'h413903b3, req_ready=0; a new request is taken only on the cycle rsp_ready=1.
- Fetch PC 0x6 and PC 0x100 (DEPTH=64) -> fault=1, instr=32'h00000013 for both.
- Same cycle: load_addr=2 with 32'hDEADBEEF and fetch PC 0x8 -> response 32'h035a02b3; the next fetch of PC 0x8 returns 32'hDEADBEEF.
- Assert reset while rsp_valid=1 and stalled -> next cycle rsp_valid=0 and init_done=0; after INIT, fetch PC 0x8 returns 32'h00000013. With IMEM_BYTE_LOAD_EN, load_be=4'b0010 with data 32'h0000AB00 yields 32'h0000AB13.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
//
// Shared definitions for the instruction memory fetch block:
//   INSTR_W            instruction width (32 bits)
//   IMEM_NOP_WORD      fill value after reset and the instruction returned on a
//                      faulting fetch (addi x0,x0,0)
//   imem_state_e       top-level sequencer states (IMEM_INIT, IMEM_RUN)
//   fault_reason_e     classification of a fetch PC
//   fetch_fault_reason helper that classifies a byte PC for a given word-index
//                      width
//
// Optional build macro used by the files that import this package:
//   IMEM_BYTE_LOAD_EN  adds per-byte write enables on the loader port
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] IMEM_NOP_WORD = 32'h0000_0013;

  typedef enum logic {
    IMEM_INIT = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_RANGE      = 2'd2
  } fault_reason_e;

  // A PC is usable only if it is word aligned and every bit above the
  // word-index field is zero; anything else would alias into the array.
  function automatic fault_reason_e fetch_fault_reason(input logic [31:0] pc,
                                                        input int          aw);
    if (pc[1:0] != 2'b00) begin
      return FAULT_MISALIGNED;
    end
    if ((pc >> (aw + 2)) != 32'd0) begin
      return FAULT_RANGE;
    end
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/instr_mem_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch_if
//
// Fetch request/response bundle between a core fetch stage (master) and the
// instruction memory (slave).
//   fetch_req_valid  master -> slave  request present
//   fetch_req_ready  slave  -> master request can be accepted
//   fetch_pc         master -> slave  byte PC of the instruction
//   fetch_rsp_valid  slave  -> master response register holds a result
//   fetch_rsp_ready  master -> slave  consumer takes the response
//   fetch_instr      slave  -> master fetched instruction
//   fetch_fault      slave  -> master misaligned or out-of-range PC
//
// No build macros affect this file.
// -----------------------------------------------------------------------------
interface instr_mem_fetch_if;
  import imem_pkg::*;

  logic               fetch_req_valid;
  logic               fetch_req_ready;
  logic [31:0]        fetch_pc;
  logic               fetch_rsp_valid;
  logic               fetch_rsp_ready;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_fault;

  modport master (
    output fetch_req_valid,
    output fetch_pc,
    output fetch_rsp_ready,
    input  fetch_req_ready,
    input  fetch_rsp_valid,
    input  fetch_instr,
    input  fetch_fault
  );

  modport slave (
    input  fetch_req_valid,
    input  fetch_pc,
    input  fetch_rsp_ready,
    output fetch_req_ready,
    output fetch_rsp_valid,
    output fetch_instr,
    output fetch_fault
  );

endinterface

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
//
// DEPTH x INSTR_W synchronous RAM, one write port and one read port, written
// so that it maps onto a standard block RAM.
//   clk    in  clock
//   we     in  write enable
//   waddr  in  word index to write
//   wdata  in  write data
//   be     in  per-byte write enables (byte i = wdata[8i+7:8i])
//   re     in  read enable; rdata updates only when re is high
//   raddr  in  word index to read
//   rdata  out registered read data, valid the cycle after re
//
// A read and a write of the same word on the same edge return the old
// contents (read-before-write). rdata holds its value while re is low, which
// the top relies on to keep a stalled response stable.
//
// Byte enables are always present here; the top ties them high when
// IMEM_BYTE_LOAD_EN is not defined.
// -----------------------------------------------------------------------------
module imem_ram
  import imem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = INSTR_W / 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [NB-1:0]      be,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // The read samples the array before this edge's write lands, which gives
  // read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
//
// Parametrised instruction memory with a valid/ready fetch interface and a
// word-wide loader port. After reset an init sequencer writes NOP_WORD into
// every word (DEPTH cycles) before the first fetch is accepted.
//
// Parameters:
//   DEPTH     number of 32-bit words; power of two, at least 4
//   NOP_WORD  fill value and the instruction returned on a fault
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   init_done  out  high once the NOP fill has completed
//   load_en    in   write load_data to word load_addr this cycle (RUN only)
//   load_addr  in   word index to write
//   load_data  in   instruction word, little-endian byte order as fetched
//   load_be    in   per-byte write enables (IMEM_BYTE_LOAD_EN builds only)
//   fetch      slave side of instr_mem_fetch_if
//
// Build macro:
//   IMEM_BYTE_LOAD_EN  when defined, adds load_be[3:0]; a load writes only the
//                      enabled bytes, load_be=0 is a no-op. When undefined
//                      every load writes the full word. The init fill always
//                      writes full words.
//
// Fetch timing: a request accepted on an edge produces its response on that
// same edge's successor... i.e. one cycle later fetch_rsp_valid is high with
// fetch_instr/fetch_fault updated. The response register is a single entry,
// so a new request is accepted whenever it is empty or being drained.
// -----------------------------------------------------------------------------
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter  int                 DEPTH    = 64,
  parameter  logic [INSTR_W-1:0] NOP_WORD = IMEM_NOP_WORD,
  localparam int                 AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               init_done,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
`ifdef IMEM_BYTE_LOAD_EN
  input  logic [3:0]         load_be,
`endif
  instr_mem_fetch_if.slave   fetch
);

  imem_state_e        state;
  logic [AW-1:0]      fill_cnt;
  logic               rsp_valid_q;
  logic               fault_q;
  logic               use_ram_q;

  logic               req_fault;
  logic               accept;
  logic [3:0]         load_be_eff;

  logic               ram_we;
  logic [AW-1:0]      ram_waddr;
  logic [INSTR_W-1:0] ram_wdata;
  logic [3:0]         ram_be;
  logic               ram_re;
  logic [AW-1:0]      ram_raddr;
  logic [INSTR_W-1:0] ram_rdata;

`ifdef IMEM_BYTE_LOAD_EN
  assign load_be_eff = load_be;
`else
  assign load_be_eff = 4'hF;
`endif

  assign req_fault = (fetch_fault_reason(fetch.fetch_pc, AW) != FAULT_NONE);

  // init_done is only high in RUN, so it doubles as the "accepting" gate.
  assign fetch.fetch_req_ready = init_done && (!rsp_valid_q || fetch.fetch_rsp_ready);
  assign accept                = fetch.fetch_req_valid && fetch.fetch_req_ready;

  // The write port belongs to the fill sequencer during INIT and to the
  // loader during RUN; loader requests during INIT are dropped.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_be    = 4'h0;
    if (state == IMEM_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = fill_cnt;
      ram_wdata = NOP_WORD;
      ram_be    = 4'hF;
    end else begin
      ram_we    = load_en;
      ram_waddr = load_addr;
      ram_wdata = load_data;
      ram_be    = load_be_eff;
    end
  end

  // Faulting fetches never touch the array; the NOP comes from the output mux.
  assign ram_re    = accept && !req_fault;
  assign ram_raddr = fetch.fetch_pc[AW+1:2];

  imem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Sequencer and response register. use_ram_q selects the RAM read register
  // over the NOP constant; it is cleared by reset so fetch_instr reads as
  // NOP_WORD straight out of reset without resetting the RAM output itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IMEM_INIT;
      fill_cnt    <= '0;
      init_done   <= 1'b0;
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      use_ram_q   <= 1'b0;
    end else begin
      case (state)
        IMEM_INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == AW'(DEPTH - 1)) begin
            state     <= IMEM_RUN;
            init_done <= 1'b1;
          end
        end
        IMEM_RUN: begin
          if (accept) begin
            rsp_valid_q <= 1'b1;
            fault_q     <= req_fault;
            use_ram_q   <= !req_fault;
          end else if (fetch.fetch_rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state <= IMEM_INIT;
        end
      endcase
    end
  end

  // Both mux inputs are registers, so there is no path from fetch_* inputs
  // to fetch_instr, and both hold steady while no request is accepted.
  assign fetch.fetch_rsp_valid = rsp_valid_q;
  assign fetch.fetch_fault     = fault_q;
  assign fetch.fetch_instr     = use_ram_q ? ram_rdata : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_fetch
//
// Directed bench for instr_mem_fetch (DEPTH=64). Stimulus sets the PC together
// with the hand-computed expected response; a negedge process pushes that
// expectation whenever the handshake will complete on the next edge and pops
// and compares whenever a response is being consumed.
// Honors IMEM_BYTE_LOAD_EN for the byte-enable vectors.
// -----------------------------------------------------------------------------
module tb_instr_mem_fetch;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [3:0]    load_be;

  logic [31:0]   exp_instr;
  logic          exp_fault;
  rsp_t          sb [$];

  int checks = 0;
  int errors = 0;

  logic [31:0] load_tbl [8] = '{
    32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
    32'h01ac8eb3, 32'h40dc0f33, 32'h00a00093, 32'h00500113
  };

  instr_mem_fetch_if fetch_bus ();

  instr_mem_fetch #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
`ifdef IMEM_BYTE_LOAD_EN
    .load_be   (load_be),
`endif
    .fetch     (fetch_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Responses are consumed on the edge after this negedge, so pop first; any
  // request accepted on that same edge is pushed behind it.
  always @(negedge clk) begin : scoreboard
    rsp_t e;
    if (!reset && fetch_bus.fetch_rsp_valid && fetch_bus.fetch_rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got %h with no expected entry", fetch_bus.fetch_instr);
      end else begin
        e = sb.pop_front();
        check("rsp_instr", fetch_bus.fetch_instr, e.instr);
        check("rsp_fault", {31'b0, fetch_bus.fetch_fault}, {31'b0, e.fault});
      end
    end
    if (!reset && fetch_bus.fetch_req_valid && fetch_bus.fetch_req_ready) begin
      sb.push_back('{instr: exp_instr, fault: exp_fault});
    end
  end

  // Leaves fetch_req_valid high so consecutive calls run back to back.
  task automatic issue(input logic [31:0] pc, input logic [31:0] ei, input logic ef,
                       output int waits);
    fetch_bus.fetch_req_valid = 1'b1;
    fetch_bus.fetch_pc        = pc;
    exp_instr                 = ei;
    exp_fault                 = ef;
    waits                     = 0;
    @(negedge clk);
    while (!fetch_bus.fetch_req_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!fetch_bus.fetch_req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout: pc %h never accepted", pc);
    end
    step();
  endtask

  task automatic wait_init(output int edges, output bit early_ready);
    edges       = 0;
    early_ready = 1'b0;
    do begin
      step();
      edges++;
      if (!init_done && fetch_bus.fetch_req_ready) early_ready = 1'b1;
    end while (!init_done && edges < 200);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waits;
    int  total;
    int  edges;
    bit  early;

    reset                     = 1'b1;
    load_en                   = 1'b0;
    load_addr                 = '0;
    load_data                 = '0;
    load_be                   = 4'hF;
    fetch_bus.fetch_req_valid = 1'b1;
    fetch_bus.fetch_pc        = 32'h0;
    fetch_bus.fetch_rsp_ready = 1'b1;
    exp_instr                 = NOP;
    exp_fault                 = 1'b0;

    repeat (2) step();
    check("rst_init_done", init_done, 0);
    check("rst_req_ready", fetch_bus.fetch_req_ready, 0);
    check("rst_rsp_valid", fetch_bus.fetch_rsp_valid, 0);
    check("rst_instr", fetch_bus.fetch_instr, NOP);
    check("rst_fault", fetch_bus.fetch_fault, 0);

    // Fetch held valid and a loader write held active across INIT: both ignored.
    load_en   = 1'b1;
    load_addr = '0;
    load_data = 32'hFFFF_FFFF;
    reset     = 1'b0;
    wait_init(edges, early);
    load_en = 1'b0;
    check("init_done_seen", init_done, 1);
    check("init_edges", edges, 64);
    check("init_ready_early", early, 0);
    step();
    fetch_bus.fetch_req_valid = 1'b0;
    drain();

    issue(32'h0, NOP, 1'b0, waits);
    fetch_bus.fetch_req_valid = 1'b0;
    drain();

    $display("[TB] load words 0..7 and fetch back to back");
    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = load_tbl[i];
      step();
    end
    load_en = 1'b0;
    total   = 0;
    for (int i = 0; i < 8; i++) begin
      issue(32'(i * 4), load_tbl[i], 1'b0, waits);
      total += waits;
    end
    fetch_bus.fetch_req_valid = 1'b0;
    check("b2b_stalls", total, 0);
    drain();

    $display("[TB] stalled response");
    fetch_bus.fetch_rsp_ready = 1'b0;
    issue(32'h4, 32'h413903b3, 1'b0, waits);
    fetch_bus.fetch_pc = 32'h8;
    exp_instr          = 32'h035a02b3;
    exp_fault          = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", fetch_bus.fetch_rsp_valid, 1);
      check("stall_instr", fetch_bus.fetch_instr, 32'h413903b3);
      check("stall_req_ready", fetch_bus.fetch_req_ready, 0);
      step();
    end
    fetch_bus.fetch_rsp_ready = 1'b1;
    @(negedge clk);
    check("release_req_ready", fetch_bus.fetch_req_ready, 1);
    step();
    fetch_bus.fetch_req_valid = 1'b0;
    drain();

    $display("[TB] faulting PCs");
    issue(32'h6, NOP, 1'b1, waits);
    issue(32'h100, NOP, 1'b1, waits);
    fetch_bus.fetch_req_valid = 1'b0;
    drain();

    $display("[TB] load and fetch same word in one cycle");
    load_en   = 1'b1;
    load_addr = AW'(2);
    load_data = 32'hDEADBEEF;
    issue(32'h8, 32'h035a02b3, 1'b0, waits);
    load_en = 1'b0;
    issue(32'h8, 32'hDEADBEEF, 1'b0, waits);
    fetch_bus.fetch_req_valid = 1'b0;
    drain();

    $display("[TB] reset during a stalled response");
    fetch_bus.fetch_rsp_ready = 1'b0;
    issue(32'hC, 32'h017b4e33, 1'b0, waits);
    fetch_bus.fetch_req_valid = 1'b0;
    step();
    check("pre_reset_rsp_valid", fetch_bus.fetch_rsp_valid, 1);
    reset = 1'b1;
    sb.delete();
    step();
    check("mid_rst_rsp_valid", fetch_bus.fetch_rsp_valid, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_req_ready", fetch_bus.fetch_req_ready, 0);
    reset                     = 1'b0;
    fetch_bus.fetch_rsp_ready = 1'b1;
    wait_init(edges, early);
    check("reinit_edges", edges, 64);
    check("reinit_ready_early", early, 0);
    issue(32'h8, NOP, 1'b0, waits);
    fetch_bus.fetch_req_valid = 1'b0;
    drain();

`ifdef IMEM_BYTE_LOAD_EN
    $display("[TB] byte-enable loads");
    load_en   = 1'b1;
    load_addr = AW'(2);
    load_data = 32'h0000AB00;
    load_be   = 4'b0010;
    step();
    load_data = 32'hFFFF_FFFF;
    load_be   = 4'b0000;
    step();
    load_en = 1'b0;
    load_be = 4'hF;
    issue(32'h8, 32'h0000AB13, 1'b0, waits);
    fetch_bus.fetch_req_valid = 1'b0;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
